// File: rtl/edge_event_arbiter.sv
// Edge-event arbiter: counts rising edges per input channel and hands the
// pending events one at a time, round-robin, to a single valid/ready consumer.
module edge_event_arbiter #(
    parameter int N     = 4,
    parameter int CNT_W = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         X,
    input  logic                 evt_ready,
    input  logic                 clr_ovf,
    output logic                 evt_valid,
    output logic [$clog2(N)-1:0] evt_id,
    output logic [N-1:0]         ovf,
    output logic                 busy
);

    localparam int ID_W = $clog2(N);

    typedef enum logic {
        IDLE,
        OFFER
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [N-1:0]       x_prev;
    logic [N-1:0]       rise;
    logic [CNT_W-1:0]   pend [N];
    logic [N-1:0]       req;
    logic [N-1:0]       take;
    logic [N-1:0]       drop;
    logic [ID_W-1:0]    rr_last;
    logic [ID_W-1:0]    sel;
    logic               any_pend;
    logic               load;
    logic               valid_next;
    logic [ID_W-1:0]    id_next;

    // Mealy edge detect: a rise is visible in the same cycle X goes high.
    always_comb begin
        rise = X & ~x_prev;
    end

    // Previous-input register feeding the edge detector.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_prev <= '0;
        end else begin
            x_prev <= X;
        end
    end

    // Request vector from registered counts only; this cycle's rise is not seen.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            req[i] = (pend[i] != '0);
        end
    end

    // Round-robin pick: lowest requester above rr_last, else lowest requester overall.
    always_comb begin
        logic            got_hi;
        logic            got_any;
        logic [ID_W-1:0] sel_hi;
        logic [ID_W-1:0] sel_any;
        got_hi  = 1'b0;
        got_any = 1'b0;
        sel_hi  = '0;
        sel_any = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i] && !got_any) begin
                got_any = 1'b1;
                sel_any = ID_W'(i);
            end
            if (req[i] && !got_hi && (ID_W'(i) > rr_last)) begin
                got_hi = 1'b1;
                sel_hi = ID_W'(i);
            end
        end
        sel      = got_hi ? sel_hi : sel_any;
        any_pend = got_any;
    end

    // FSM next state and next registered outputs; a load takes one pending event.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        valid_next = evt_valid;
        id_next    = evt_id;
        unique case (state)
            IDLE: begin
                if (any_pend) begin
                    load       = 1'b1;
                    valid_next = 1'b1;
                    id_next    = sel;
                    state_next = OFFER;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    if (any_pend) begin
                        load       = 1'b1;
                        valid_next = 1'b1;
                        id_next    = sel;
                    end else begin
                        valid_next = 1'b0;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
            end
        endcase
    end

    // Per-channel take strobe and saturation drop detection.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            take[i] = load && (sel == ID_W'(i));
            drop[i] = rise[i] && !take[i] && (pend[i] == '1);
        end
    end

    // Pending counters: +rise -take, saturating at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < N; i++) begin
                pend[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (rise[i] && !take[i]) begin
                    if (pend[i] != '1) begin
                        pend[i] <= pend[i] + 1'b1;
                    end
                end else if (take[i] && !rise[i]) begin
                    pend[i] <= pend[i] - 1'b1;
                end
            end
        end
    end

    // Sticky overflow flags; a new drop beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf <= '0;
        end else begin
            ovf <= (ovf & ~{N{clr_ovf}}) | drop;
        end
    end

    // FSM state, registered offer outputs and round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            evt_valid <= 1'b0;
            evt_id    <= '0;
            rr_last   <= ID_W'(N - 1);
        end else begin
            state     <= state_next;
            evt_valid <= valid_next;
            evt_id    <= id_next;
            if (load) begin
                rr_last <= sel;
            end
        end
    end

    // Busy while an offer is out or any event is still counted.
    always_comb begin
        busy = evt_valid | any_pend;
    end

endmodule
